// File: rtl/mult_operand_feeder_pkg.sv
// Shared types and defaults for the multiplier operand feeder.
// State encodings, default geometry and the timer sizing helper live here.
package mult_operand_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int DEF_WIDTH   = 10;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 32;

  // Bits needed to count WAIT cycles 0..timeout-1.
  function automatic int timer_width(input int timeout);
    if (timeout > 1) begin
      return $clog2(timeout);
    end else begin
      return 1;
    end
  endfunction

  localparam int DEF_TIMER_W = timer_width(DEF_TIMEOUT);

endpackage

// File: rtl/mult_operand_feeder_operand_fifo.sv
// Synchronous operand FIFO: power-of-two depth, wrapping pointers, no bypass.
// Head data is presented combinationally from the read pointer.
module operand_fifo
  import mult_operand_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mult_operand_feeder.sv
// Buffers packed operands, sequences them through a handshake multiplier and
// captures each product into a one-entry result register; flags a hung multiplier.
module mult_operand_feeder
  import mult_operand_feeder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             mul_enable,
  output logic [WIDTH-1:0] mul_data,
  input  logic             mul_ready,
  input  logic [WIDTH-1:0] mul_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic             err_timeout,
  output logic [7:0]       done_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e           state_q;
  logic             mul_enable_q;
  logic [WIDTH-1:0] mul_data_q;
  logic [TW-1:0]    timer_q;
  logic             ready_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             err_q;
  logic [7:0]       done_q;

  logic             push_s;
  logic             start_s;
  logic [WIDTH-1:0] fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;

  // in_ready is held low while reset is asserted, even though the FIFO reads empty.
  assign in_ready = rst && !fifo_full_s && (fifo_count_s < CW'(DEPTH));
  assign push_s   = in_valid && in_ready;

  operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (in_data),
    .pop_i       (start_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // A new op may start only when the result slot is free or being drained this edge.
  always_comb begin
    start_s = 1'b0;
    if ((state_q == ST_IDLE) && !fifo_empty_s && (!res_valid_q || res_ready)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Sequencer: issue pulse, rising-edge completion detect, timeout, result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mul_enable_q <= 1'b0;
      mul_data_q   <= {WIDTH{1'b0}};
      timer_q      <= {TW{1'b0}};
      ready_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= {WIDTH{1'b0}};
      err_q        <= 1'b0;
      done_q       <= 8'd0;
    end else begin
      ready_q      <= mul_ready;
      mul_enable_q <= 1'b0;
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q      <= ST_ISSUE;
            mul_data_q   <= fifo_head_s;
            timer_q      <= {TW{1'b0}};
            mul_enable_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is checked first so it beats a coincident timeout.
          if (mul_ready && !ready_q) begin
            res_data_q  <= mul_out;
            res_valid_q <= 1'b1;
            done_q      <= done_q + 8'd1;
            state_q     <= ST_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mul_enable  = mul_enable_q;
  assign mul_data    = mul_data_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;
  assign done_count  = done_q;

endmodule
